// File: rtl/wisc_pkg.sv
// Shared WISC-S25 definitions: opcode constants and the fetch-unit state encoding.
package wisc_pkg;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/wisc_fetch_skid.sv
// One-entry {instr, pc} skid buffer behind the fetch output register, with flush.
module wisc_fetch_skid
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_instr,
    input  logic [15:0] push_pc,
    output logic        valid,
    output logic [15:0] instr,
    output logic [15:0] pc
);

    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;

    // A push in the same cycle as a pop replaces the departing entry.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            instr_d = push_instr;
            pc_d    = push_pc;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= 16'h0000;
            pc_q    <= 16'h0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/wisc_fetch.sv
// WISC-S25 instruction fetch: PC, 1-cycle imem requests, valid/ready output with skid, HLT stop.
// Define WISC_FETCH_PERF_EN to build the delivered-instruction counter on perf_fetch_cnt.
module wisc_fetch
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic [15:0] out_pc_plus2,
    output logic        halted,
    output logic [15:0] perf_fetch_cnt
);

    localparam logic [1:0] S_RUN       = RUN;
    localparam logic [1:0] S_HALT_PEND = HALT_PEND;
    localparam logic [1:0] S_HALTED    = HALTED;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [15:0] inflight_pc_q, inflight_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_instr_q, out_instr_d;
    logic [15:0] out_pc_q, out_pc_d;
    logic [15:0] out_pc_plus2_q, out_pc_plus2_d;

    logic        skid_valid;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;
    logic        skid_push;
    logic        skid_pop;

    logic [1:0]  occ;
    logic [1:0]  occ_after;
    logic        issue;
    logic        ret_ok;
    logic        ret_hlt;
    logic        out_free;
    logic        transfer;

    // Occupancy counts the return landing this cycle, so at most two words are ever owed.
    always_comb begin
        occ       = {1'b0, out_valid_q} + {1'b0, skid_valid} + {1'b0, inflight_q};
        occ_after = occ - {1'b0, out_valid_q & out_ready};
        issue     = redirect_valid | ((state_q == S_RUN) && (occ_after < 2'd2));
        imem_addr = redirect_valid ? (redirect_pc & 16'hFFFE) : pc_q;
    end

    assign imem_rd_en = rst_n & issue;
    assign out_valid  = out_valid_q & ~redirect_valid;
    assign halted     = (state_q == S_HALTED) & ~redirect_valid;
    assign transfer   = out_valid & out_ready;

    // Returns arriving after HLT (or squashed by a redirect) are dropped here.
    assign ret_ok    = inflight_q & ~redirect_valid & (state_q == S_RUN);
    assign ret_hlt   = ret_ok & (imem_data[15:12] == OP_HLT);
    assign out_free  = ~out_valid_q | out_ready;
    assign skid_pop  = out_free & skid_valid;
    assign skid_push = ret_ok & (~out_free | skid_valid);

    wisc_fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (skid_push),
        .pop        (skid_pop),
        .push_instr (imem_data),
        .push_pc    (inflight_pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_comb begin
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus2_d = out_pc_plus2_q;
        if (redirect_valid) begin
            out_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_d    = 1'b1;
                out_instr_d    = skid_instr;
                out_pc_d       = skid_pc;
                out_pc_plus2_d = skid_pc + 16'd2;
            end else if (ret_ok) begin
                out_valid_d    = 1'b1;
                out_instr_d    = imem_data;
                out_pc_d       = inflight_pc_q;
                out_pc_plus2_d = inflight_pc_q + 16'd2;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        pc_d          = issue ? imem_addr + 16'd2 : pc_q;
        inflight_d    = issue;
        inflight_pc_d = imem_addr;
        state_d       = state_q;
        if (redirect_valid) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:       if (ret_hlt) state_d = S_HALT_PEND;
                // Nothing younger than the HLT is kept, so an HLT transfer is the HLT.
                S_HALT_PEND: if (transfer && out_instr_q[15:12] == OP_HLT) state_d = S_HALTED;
                S_HALTED:    state_d = S_HALTED;
                default:     state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RUN;
            pc_q           <= {RESET_PC[15:1], 1'b0};
            inflight_q     <= 1'b0;
            inflight_pc_q  <= 16'h0000;
            out_valid_q    <= 1'b0;
            out_instr_q    <= 16'h0000;
            out_pc_q       <= 16'h0000;
            out_pc_plus2_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inflight_q     <= inflight_d;
            inflight_pc_q  <= inflight_pc_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus2_q <= out_pc_plus2_d;
        end
    end

    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus2 = out_pc_plus2_q;

`ifdef WISC_FETCH_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q + {15'd0, transfer};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 16'h0000;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_fetch_cnt = perf_q;
`else
    assign perf_fetch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wisc_fetch.sv
// Directed bench for wisc_fetch: cycle table for streaming/stall/redirect, hand sequences for HLT, wrap, reset.
module tb_wisc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_plus2;
    logic        halted;
    logic [15:0] perf_fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef WISC_FETCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    wisc_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus2   (out_pc_plus2),
        .halted         (halted),
        .perf_fetch_cnt (perf_fetch_cnt)
    );

    // Instruction memory: ADD-class words tagged with their address.
    logic [15:0] mem [0:32767];

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= mem[imem_addr[15:1]];
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {4'h0, a[12:1]};
    endfunction

    function automatic logic [15:0] exp_perf(input int n);
        return PERF_ON ? 16'(n) : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [15:0] rpc;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs [15];

    int          hlt_xfer;
    int          halt_cyc;
    int          rd_late;
    logic [15:0] last_addr;
    logic [15:0] hlt_pc;
    logic        seen_a;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = word_at(16'(i * 2));

        // cycle-by-cycle from reset release: stream, 3-cycle stall, fill skid, redirect to 0x0041
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0002};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h0004};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h0004};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 16'h0004};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0004};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'h0006};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 1'b1, 16'h0008};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000E, 1'b1, 16'h000A};
        vecs[11] = '{1'b0, 1'b1, 16'h0041, 1'b1, 16'h0040, 1'b0, 16'h0000};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b0, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b1, 16'h0040};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0046, 1'b1, 16'h0042};

        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst rd_en", imem_rd_en, 0);
        check("rst halted", halted, 0);
        check("rst out_instr", out_instr, 0);
        check("rst out_pc", out_pc, 0);
        check("rst out_pc_plus2", out_pc_plus2, 0);
        check("rst perf", perf_fetch_cnt, 0);

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0) rst_n = 1'b1;
            out_ready      = vecs[k].ready;
            redirect_valid = vecs[k].redir;
            redirect_pc    = vecs[k].rpc;
            #1;
            $display("row %0d: rd_en=%0b addr=%h valid=%0b pc=%h instr=%h",
                     k, imem_rd_en, imem_addr, out_valid, out_pc, out_instr);
            check($sformatf("row%0d rd_en", k), imem_rd_en, vecs[k].e_rd);
            check($sformatf("row%0d addr", k), imem_addr, vecs[k].e_addr);
            check($sformatf("row%0d valid", k), out_valid, vecs[k].e_valid);
            if (vecs[k].e_valid) begin
                check($sformatf("row%0d pc", k), out_pc, vecs[k].e_pc);
                check($sformatf("row%0d instr", k), out_instr, word_at(vecs[k].e_pc));
                check($sformatf("row%0d plus2", k), out_pc_plus2, vecs[k].e_pc + 16'd2);
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("table perf", perf_fetch_cnt, exp_perf(7));

        // HLT at 0x0008 with out_ready held high
        mem[4] = 16'hF000;
        do_reset();
        hlt_xfer  = -1;
        halt_cyc  = -1;
        rd_late   = 0;
        last_addr = 16'h0000;
        hlt_pc    = 16'h0000;
        seen_a    = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (imem_rd_en) last_addr = imem_addr;
            if (imem_rd_en && c >= 7 && c < 27) rd_late++;
            if (out_valid && out_ready && out_instr == 16'hF000 && hlt_xfer < 0) begin
                hlt_xfer = c;
                hlt_pc   = out_pc;
            end
            if (halted && halt_cyc < 0) halt_cyc = c;
            if (out_valid && out_pc == 16'h000A) seen_a = 1'b1;
        end
        $display("hlt: xfer=%0d halted_at=%0d last_addr=%h", hlt_xfer, halt_cyc, last_addr);
        check("hlt last addr", last_addr, 16'h000A);
        check("hlt xfer cycle", 16'(hlt_xfer), 16'd6);
        check("hlt pc", hlt_pc, 16'h0008);
        check("halted cycle", 16'(halt_cyc), 16'd7);
        check("hlt rd_en idle 20", 16'(rd_late), 16'd0);
        check("hlt no 0x000A out", seen_a, 0);
        check("hlt still halted", halted, 1);
        check("hlt perf", perf_fetch_cnt, exp_perf(5));

        // Redirect out of HALTED to 0xFFFD (bit 0 dropped), then wrap past 0xFFFE
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFD;
        #1;
        check("wrap redir rd_en", imem_rd_en, 1);
        check("wrap redir addr", imem_addr, 16'hFFFC);
        check("wrap redir halted", halted, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("wrap c1 addr", imem_addr, 16'hFFFE);
        check("wrap c1 valid", out_valid, 0);
        check("wrap c1 halted", halted, 0);
        @(negedge clk);
        #1;
        check("wrap c2 addr", imem_addr, 16'h0000);
        check("wrap c2 pc", out_pc, 16'hFFFC);
        check("wrap c2 plus2", out_pc_plus2, 16'hFFFE);
        @(negedge clk);
        #1;
        check("wrap c3 pc", out_pc, 16'hFFFE);
        check("wrap c3 instr", out_instr, 16'h0FFF);
        check("wrap c3 plus2", out_pc_plus2, 16'h0000);
        @(negedge clk);
        #1;
        check("wrap c4 pc", out_pc, 16'h0000);
        check("wrap c4 instr", out_instr, 16'h0000);
        mem[4] = word_at(16'h0008);

        // Asynchronous reset mid-stream with a request in flight
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
        end
        check("pre-rst pc", out_pc, 16'h0004);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-rst valid", out_valid, 0);
        check("mid-rst rd_en", imem_rd_en, 0);
        check("mid-rst pc", out_pc, 0);
        check("mid-rst instr", out_instr, 0);
        check("mid-rst plus2", out_pc_plus2, 0);
        check("mid-rst perf", perf_fetch_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("restart addr", imem_addr, 16'h0000);
        check("restart rd_en", imem_rd_en, 1);
        @(negedge clk);
        #1;
        check("restart c1 valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("restart c2 valid", out_valid, 1);
        check("restart c2 pc", out_pc, 16'h0000);
        check("restart c2 instr", out_instr, 16'h0000);
        repeat (3) @(negedge clk);
        #1;
        check("restart pc", out_pc, 16'h0006);
        check("restart perf", perf_fetch_cnt, exp_perf(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
